// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS main controller.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] HW_WORD = 2'b00;
    localparam logic [1:0] HW_LH   = 2'b11;
    localparam logic [1:0] HW_LHU  = 2'b10;

    // Registered datapath control bundle
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] half_word_signed;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic [1:0] half_word_sel(input logic [5:0] op);
        case (op)
            OP_LH:   return HW_LH;
            OP_LHU:  return HW_LHU;
            default: return HW_WORD;
        endcase
    endfunction

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of one memory access; expired flags the last allowed wait cycle.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller with req/ready memory handshake and wait timeout.
// Define MC_JUMP_EN to build the JUMP state for opcode 0x02.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                reg_write,
    output logic                reg_dest,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [1:0]          half_word_signed,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                mem_error,
    output logic                illegal_op,
    output logic [3:0]          state
);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q;
    logic                run_q;
    ctrl_t               ctrl_q, ctrl_d;
    logic                mem_error_q, mem_error_d;
    logic                illegal_q, illegal_d;
    logic                expired, timer_clear, timer_en;
    logic [5:0]          op_in, op_lat;

    assign op_in  = 6'(opcode);
    assign op_lat = 6'(op_q);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired)
    );

    // Timer restarts on every new access, including a timed-out FETCH retrying itself
    assign timer_en    = is_wait_state(state_q) && !mem_ready;
    assign timer_clear = is_wait_state(state_d) && !(timer_en && !expired);

    // IDLE holds one cycle after reset release so the first FETCH lands on the second edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            op_q        <= '0;
            ctrl_q      <= '0;
            mem_error_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            ctrl_q      <= ctrl_d;
            mem_error_q <= mem_error_d;
            illegal_q   <= illegal_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Next state, error pulses and controls decoded from the next state
    always_comb begin
        state_d     = state_q;
        mem_error_d = 1'b0;
        illegal_d   = 1'b0;
        ctrl_d      = '0;

        case (state_q)
            S_IDLE:      if (run_q) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d     = S_FETCH;
                    mem_error_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (op_in)
                    OP_RTYPE:            state_d = S_R_EXEC;
                    OP_ADDI:             state_d = S_ADDI_EXEC;
                    OP_LW, OP_LH, OP_LHU,
                    OP_SW:               state_d = S_MEM_ADDR;
                    OP_BEQ:              state_d = S_BRANCH;
`ifdef MC_JUMP_EN
                    OP_J:                state_d = S_JUMP;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  state_d = (op_lat == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (expired) begin
                    state_d     = S_FETCH;
                    mem_error_d = 1'b1;
                end
            end
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (expired) begin
                    state_d     = S_FETCH;
                    mem_error_d = 1'b1;
                end
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
`ifdef MC_JUMP_EN
            S_JUMP:      state_d = S_FETCH;
`endif
            default:     state_d = S_IDLE;
        endcase

        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
            end
            S_DECODE:    ctrl_d.alu_src_b = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
                ctrl_d.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_d.mem_req = 1'b1;
                ctrl_d.i_or_d  = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_d.mem_req   = 1'b1;
                ctrl_d.i_or_d    = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_d.reg_write        = 1'b1;
                ctrl_d.mem_to_reg       = 1'b1;
                ctrl_d.half_word_signed = half_word_sel(op_lat);
            end
            S_R_EXEC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dest  = 1'b1;
            end
            S_ADDI_WB:   ctrl_d.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_op        = ALUOP_SUB;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_source     = 2'b01;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_source = 2'b10;
            end
`endif
            default:     ctrl_d = '0;
        endcase
    end

    // IR and PC load in FETCH follow the memory completing the instruction read
    assign ir_write         = (state_q == S_FETCH) && mem_ready;
    assign pc_write         = ctrl_q.pc_write || ir_write;
    assign mem_req          = ctrl_q.mem_req;
    assign mem_write        = ctrl_q.mem_write;
    assign i_or_d           = ctrl_q.i_or_d;
    assign pc_write_cond    = ctrl_q.pc_write_cond;
    assign reg_write        = ctrl_q.reg_write;
    assign reg_dest         = ctrl_q.reg_dest;
    assign mem_to_reg       = ctrl_q.mem_to_reg;
    assign alu_src_a        = ctrl_q.alu_src_a;
    assign alu_src_b        = ctrl_q.alu_src_b;
    assign pc_source        = ctrl_q.pc_source;
    assign half_word_signed = ctrl_q.half_word_signed;
    assign alu_op           = ALUOP_W'(ctrl_q.alu_op);
    assign mem_error        = mem_error_q;
    assign illegal_op       = illegal_q;
    assign state            = 4'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-cycle reference trace built from the instruction rules.
module tb_multicycle_control;

    localparam int unsigned TIMEOUT = 4;
`ifdef MC_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3,
                   ST_MEM_READ = 4, ST_MEM_WB = 5, ST_MEM_WRITE = 6, ST_R_EXEC = 7,
                   ST_R_WB = 8, ST_BRANCH = 9, ST_ADDI_EXEC = 10, ST_ADDI_WB = 11,
                   ST_JUMP = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic       reg_write, reg_dest, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_source, half_word_signed, alu_op;
    logic       mem_error, illegal_op;
    logic [3:0] state;

    multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .reg_write(reg_write), .reg_dest(reg_dest), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .half_word_signed(half_word_signed), .alu_op(alu_op),
        .mem_error(mem_error), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] op;
        logic       err;
        logic       ill;
        logic [5:0] lat;
    } step_t;

    step_t      plan[$];
    step_t      sb[$];
    step_t      mon_s;
    logic [23:0] mon_exp;
    logic [5:0] m_lat;
    bit         pend_err, pend_ill;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [23:0] act;
    assign act = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                  reg_write, reg_dest, mem_to_reg, alu_src_a, alu_src_b, pc_source,
                  half_word_signed, alu_op, mem_error, illegal_op, state};

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    // Expected outputs for one cycle, straight from the per-state output table
    function automatic logic [23:0] expect_vec(input step_t s);
        logic mreq, mwr, iod, irw, pcw, pcwc, rw, rd, m2r, asa;
        logic [1:0] asb, pcs, hws, aop;
        {mreq, mwr, iod, irw, pcw, pcwc, rw, rd, m2r, asa} = '0;
        {asb, pcs, hws, aop} = '0;
        case (int'(s.st))
            ST_FETCH:     begin mreq = 1; asb = 2'b01; irw = s.rdy; pcw = s.rdy; end
            ST_DECODE:    asb = 2'b11;
            ST_MEM_ADDR, ST_ADDI_EXEC: begin asa = 1; asb = 2'b10; aop = 2'b00; end
            ST_MEM_READ:  begin mreq = 1; iod = 1; end
            ST_MEM_WRITE: begin mreq = 1; iod = 1; mwr = 1; end
            ST_MEM_WB: begin
                rw = 1; m2r = 1;
                hws = (s.lat == 6'h21) ? 2'b11 : (s.lat == 6'h25) ? 2'b10 : 2'b00;
            end
            ST_R_EXEC:    begin asa = 1; aop = 2'b10; end
            ST_R_WB:      begin rw = 1; rd = 1; end
            ST_ADDI_WB:   rw = 1;
            ST_BRANCH:    begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            ST_JUMP:      begin pcw = 1; pcs = 2'b10; end
            default:      ;
        endcase
        return {mreq, mwr, iod, irw, pcw, pcwc, rw, rd, m2r, asa, asb, pcs, hws, aop,
                s.err, s.ill, s.st};
    endfunction

    task automatic add(input int st, input bit rdy, input logic [5:0] op);
        step_t s;
        s.st  = 4'(st);
        s.rdy = rdy;
        s.op  = op;
        s.err = pend_err;
        s.ill = pend_ill;
        s.lat = m_lat;
        pend_err = 1'b0;
        pend_ill = 1'b0;
        plan.push_back(s);
    endtask

    // A memory access lasting w wait cycles; w >= TIMEOUT means it times out
    task automatic add_mem(input int st, input int w, output bit ok);
        int n_low;
        n_low = (w >= int'(TIMEOUT)) ? int'(TIMEOUT) : w;
        for (int i = 0; i < n_low; i++) add(st, 1'b0, junk());
        ok = (w < int'(TIMEOUT));
        if (ok) add(st, 1'b1, junk());
        else    pend_err = 1'b1;
    endtask

    task automatic gen_instr(input logic [5:0] op, input int wf, input int wm);
        bit ok;
        add_mem(ST_FETCH, wf, ok);
        if (!ok) return;
        add(ST_DECODE, 1'($urandom), op);
        m_lat = op;
        case (op)
            6'h00: begin add(ST_R_EXEC, 1'($urandom), junk()); add(ST_R_WB, 1'($urandom), junk()); end
            6'h08: begin add(ST_ADDI_EXEC, 1'($urandom), junk()); add(ST_ADDI_WB, 1'($urandom), junk()); end
            6'h23, 6'h21, 6'h25: begin
                add(ST_MEM_ADDR, 1'($urandom), junk());
                add_mem(ST_MEM_READ, wm, ok);
                if (ok) add(ST_MEM_WB, 1'($urandom), junk());
            end
            6'h2B: begin
                add(ST_MEM_ADDR, 1'($urandom), junk());
                add_mem(ST_MEM_WRITE, wm, ok);
            end
            6'h04: add(ST_BRANCH, 1'($urandom), junk());
            6'h02: if (JUMP_EN) add(ST_JUMP, 1'($urandom), junk()); else pend_ill = 1'b1;
            default: pend_ill = 1'b1;
        endcase
    endtask

    // Driver: applies one planned cycle after each rising edge and hands it to the scoreboard
    task automatic run_plan(input int max_steps);
        step_t cur;
        int k = 0;
        while (plan.size() > 0 && k < max_steps) begin
            @(posedge clk);
            #1;
            cur = plan.pop_front();
            mem_ready = cur.rdy;
            opcode    = cur.op;
            sb.push_back(cur);
            k++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (act !== 24'h0) begin
            n_fail++;
            $display("FAIL %s: outputs got=%h want=000000", name, act);
        end
    endtask

    // Monitor: compares every presented cycle against the head of the scoreboard
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_s   = sb.pop_front();
            mon_exp = expect_vec(mon_s);
            n_tests++;
            if (act !== mon_exp) begin
                n_fail++;
                $display("FAIL cycle: state got=%0d want=%0d, outputs got=%h want=%h",
                         state, mon_s.st, act, mon_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [8];
        logic [5:0] op;
        int sel, wf, wm;
        ops = '{6'h00, 6'h08, 6'h23, 6'h21, 6'h25, 6'h2B, 6'h04, 6'h02};

        reset = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
        m_lat = 6'h00; pend_err = 1'b0; pend_ill = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_hold");
        #2 reset = 1'b1;

        add(ST_IDLE, 1'b1, junk());
        gen_instr(6'h23, 0, 0);
        gen_instr(6'h21, 0, 0);
        gen_instr(6'h25, 0, 0);
        gen_instr(6'h2B, 0, 3);
        gen_instr(6'h00, 0, 0);
        gen_instr(6'h08, 0, 0);
        gen_instr(6'h04, 0, 0);
        gen_instr(6'h23, TIMEOUT, 0);
        gen_instr(6'h2B, TIMEOUT - 1, 0);
        gen_instr(6'h23, 0, TIMEOUT - 1);
        gen_instr(6'h23, 0, TIMEOUT);
        gen_instr(6'h2B, 0, TIMEOUT);
        gen_instr(6'h3F, 0, 0);
        gen_instr(6'h02, 0, 0);
        gen_instr(6'h00, 0, 0);
        run_plan(1 << 30);

        repeat (300) begin
            sel = int'($urandom_range(0, 8));
            op  = (sel == 8) ? junk() : ops[sel];
            wf  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT)) : 0;
            wm  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TIMEOUT)) : 0;
            gen_instr(op, wf, wm);
        end
        run_plan(1 << 30);

        // Abort a load in MEM_READ with an asynchronous reset
        gen_instr(6'h23, 0, TIMEOUT);
        run_plan(4);
        #1 reset = 1'b0;
        #1 check_zero("reset_mid_read");
        plan.delete();
        m_lat = 6'h00; pend_err = 1'b0; pend_ill = 1'b0;
        @(negedge clk);
        check_zero("reset_mid_hold");
        #2 reset = 1'b1;
        add(ST_IDLE, 1'b0, junk());
        gen_instr(6'h3F, 0, 0);
        gen_instr(6'h04, 1, 0);
        add(ST_FETCH, 1'b0, junk());
        run_plan(1 << 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS main controller: a registered state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It drives the multi-cycle datapath control lines and a req/ready memory handshake, and bounds every memory access with a wait-state timeout. It replaces the single-cycle opcode decoder and sits between the instruction register's opcode field and the shared-memory datapath.

## Interface
- OPCODE_W, 6: opcode field width.
- ALUOP_W, 2: alu_op width; bits above [1] are always driven 0.
- TIMEOUT, 16: maximum wait cycles per memory access; must be ≥2.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- opcode  in  OPCODE_W  IR opcode field; sampled only in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req, mem_write, i_or_d  out  1  memory request, write strobe, address select (0=PC, 1=ALUOut).
- ir_write, pc_write, pc_write_cond  out  1  IR load, unconditional PC load, PC load qualified by ALU zero.
- reg_write, reg_dest, mem_to_reg, alu_src_a  out  1  register-file and ALU operand controls.
- alu_src_b, pc_source, half_word_signed  out  2  operand B select, PC mux select, load width (00 word, 11 lh, 10 lhu).
- alu_op  out  ALUOP_W  00 add, 01 sub, 10 funct-decoded.
- mem_error, illegal_op  out  1  one-cycle error pulses.
- state  out  4  current state, for debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, ADDI_EXEC=10, ADDI_WB=11, JUMP=12.
- IDLE → FETCH unconditionally. FETCH → DECODE on mem_ready.
- DECODE latches opcode and branches on it:
  - 0x00 → R_EXEC → R_WB → FETCH.
  - 0x08 → ADDI_EXEC → ADDI_WB → FETCH.
  - 0x23/0x21/0x25 → MEM_ADDR → MEM_READ → MEM_WB → FETCH.
  - 0x2B → MEM_ADDR → MEM_WRITE → FETCH.
  - 0x04 → BRANCH → FETCH.
  - Any other opcode → FETCH, with illegal_op pulsed.
- MEM_READ and MEM_WRITE advance only on mem_ready.
- Outputs are Moore-decoded from state and the latched opcode. Any signal not listed below is 0 in that state.
  - FETCH: mem_req=1, alu_src_b=01; ir_write=pc_write=mem_ready.
  - DECODE: alu_src_b=11 (branch target precompute).
  - MEM_ADDR, ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_req=1, i_or_d=1.
  - MEM_WRITE: mem_req=1, i_or_d=1, mem_write=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, half_word_signed from the latched opcode (0x23→00, 0x21→11, 0x25→10).
  - R_EXEC: alu_src_a=1, alu_op=10.
  - R_WB: reg_write=1, reg_dest=1.
  - ADDI_WB: reg_write=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
- Wait timer: cleared on entry to FETCH, MEM_READ or MEM_WRITE. It increments each cycle the FSM is in one of those states with mem_ready low.
- Timeout: when the timer reaches TIMEOUT−1 with mem_ready still low, the FSM goes to FETCH and mem_error pulses for one cycle.
- If mem_ready is high on the cycle the timer reaches TIMEOUT−1, the access completes normally and there is no error.

## Timing
- Reset (async, reset low): state=IDLE, all outputs 0, timer 0, latched opcode 0.
- First FETCH occurs on the 2nd rising edge after reset deasserts.
- Cycles per instruction with zero wait states: lw/lh/lhu 5; sw, R-type and addi 4; beq 3; j 3.
- Each wait cycle adds 1 cycle per memory state.
- mem_error and illegal_op are registered and assert the cycle after the event.
- Reset asserted mid-instruction aborts immediately: outputs drop asynchronously and no write-back occurs.
- opcode changes outside DECODE have no effect.

## Configuration
- MC_JUMP_EN defined: opcode 0x02 in DECODE → JUMP → FETCH.
- MC_JUMP_EN undefined: 0x02 is illegal (illegal_op pulses), the JUMP state is not built, and pc_source never equals 10.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit) and opcode localparams (OP_RTYPE, OP_ADDI, OP_LW, OP_LH, OP_LHU, OP_SW, OP_BEQ, OP_J);
  - ALU-op constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - half-word encodings.
- One sub-module, mem_wait_timer: clear/enable inputs, parameter TIMEOUT, expired output.

## Test plan
- Reset low mid-MEM_READ, then release → state=0 and all outputs 0 during reset; state=1 two edges after release.
- opcode 0x23, mem_ready always 1 → states 1,2,3,4,5,1; reg_write=mem_to_reg=1 in state 5 with half_word_signed=00.
- opcode 0x21, then 0x25 → half_word_signed=11, then 10, in MEM_WB.
- opcode 0x2B, mem_ready held low 3 cycles in MEM_WRITE → mem_write held 4 cycles, then FETCH, no mem_error.
- mem_ready held low in FETCH with TIMEOUT=4 → mem_error pulses once; FETCH restarts with timer cleared. Repeat with ready rising on the 4th wait cycle → no error.
- opcode 0x3F, then 0x02 in both builds → illegal_op pulse for 0x3F; 0x02 reaches JUMP (pc_write=1, pc_source=10) only with MC_JUMP_EN defined.
